// File: rtl/w5300_bus_model.sv
// W5300 host-bus slave model: register file, RX/TX FIFO data window, level interrupt, access log.
// Latency: strobes pass a 2-flop synchroniser; commit and log pulse land 3 clk after strobe release.
// Backpressure: none on the bus; full/empty FIFO operations are dropped. W5300_BUS_MODEL_ERRCHK_EN enables err.
module w5300_bus_model #(
  parameter int AW        = 10,
  parameter int DW        = 8,
  parameter int REGS      = 64,
  parameter int FIFO_ADDR = 'h02E,
  parameter int IMR_ADDR  = 'h002,
  parameter int FDEPTH    = 16,
  parameter int INT_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           addr,
  input  logic                    cs_n,
  input  logic                    rd_n,
  input  logic                    wr_n,
  inout  wire  [DW-1:0]           d,
  output logic                    int_n,
  input  logic                    rx_push,
  input  logic [DW-1:0]           rx_wdata,
  output logic                    rx_full,
  output logic [$clog2(FDEPTH):0] rx_count,
  input  logic                    tx_pop,
  output logic [DW-1:0]           tx_rdata,
  output logic                    tx_empty,
  output logic                    log_valid,
  output logic [AW-1:0]           log_addr,
  output logic                    log_rnw,
  output logic [DW-1:0]           log_data,
  output logic [15:0]             acc_cnt,
  output logic                    err
);

  localparam int              IW      = $clog2(REGS);
  localparam int              PW      = $clog2(FDEPTH);
  localparam int              IMR_IDX = IMR_ADDR % REGS;
  localparam logic [AW-1:0]   FADDR   = AW'(FIFO_ADDR);
  localparam logic [PW:0]     DEPTH_C = (PW+1)'(FDEPTH);
  localparam logic [PW:0]     LVL_C   = (PW+1)'(INT_LEVEL);

  function automatic logic [IW-1:0] reg_idx(input logic [AW-1:0] a);
    return IW'(32'(a) % REGS);
  endfunction

  // Strobe decode and synchroniser state
  logic          raw_rd, raw_wr, g_rd, g_wr;
  logic          block_q;
  logic [1:0]    rd_sync_q, wr_sync_q;
  logic          rd_prev_q, wr_prev_q;
  logic          abort_q;
  logic          bus_idle, rd_fall, wr_fall, rd_commit, wr_commit;

  // Captured access
  logic [AW-1:0] rd_addr_q, wr_addr_q;
  logic [DW-1:0] rd_data_q, wr_data_q;

  // Storage
  logic [DW-1:0] regs_q [REGS];
  logic [DW-1:0] rx_mem [FDEPTH];
  logic [DW-1:0] tx_mem [FDEPTH];
  logic [PW-1:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic [PW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic          rx_empty, tx_full;
  logic          rx_push_ok, rx_pop_ok, tx_push_ok, tx_pop_ok, reg_we;
  logic [DW-1:0] rx_head, rd_val;

  // Log and interrupt
  logic          log_valid_q, log_rnw_q, int_n_q;
  logic [AW-1:0] log_addr_q;
  logic [DW-1:0] log_data_q;
  logic [15:0]   acc_cnt_q;

  // A strobe still held when reset releases is ignored until the bus goes idle,
  // so an access in flight across reset can never commit.
  assign raw_rd = ~(cs_n | rd_n);
  assign raw_wr = ~(cs_n | wr_n);
  assign g_rd   = raw_rd & ~block_q;
  assign g_wr   = raw_wr & ~block_q;

  assign bus_idle  = ~g_rd & ~g_wr & ~(|rd_sync_q) & ~(|wr_sync_q);
  assign rd_fall   = rd_prev_q & ~rd_sync_q[1];
  assign wr_fall   = wr_prev_q & ~wr_sync_q[1];
  assign rd_commit = rd_fall & ~abort_q;
  assign wr_commit = wr_fall & ~abort_q;

  // Read data path: combinational drive while the raw read strobe is active
  assign rx_head = rx_empty ? '0 : rx_mem[rx_rptr_q];
  assign rd_val  = (addr == FADDR) ? rx_head : regs_q[reg_idx(addr)];
  assign d       = raw_rd ? rd_val : {DW{1'bz}};

  // FIFO handshakes; a push into a full FIFO is accepted only alongside a pop
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_full    = (rx_cnt_q == DEPTH_C);
  assign tx_empty   = (tx_cnt_q == '0);
  assign tx_full    = (tx_cnt_q == DEPTH_C);
  assign rx_pop_ok  = rd_commit & (rd_addr_q == FADDR) & ~rx_empty;
  assign rx_push_ok = rx_push & (~rx_full | rx_pop_ok);
  assign tx_pop_ok  = tx_pop & ~tx_empty;
  assign tx_push_ok = wr_commit & (wr_addr_q == FADDR) & (~tx_full | tx_pop_ok);
  assign reg_we     = wr_commit & (wr_addr_q != FADDR);

  assign rx_count = rx_cnt_q;
  assign tx_rdata = tx_empty ? '0 : tx_mem[tx_rptr_q];

  // Synchronisers, edge history and overlap abort tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q   <= 1'b1;
      rd_sync_q <= '0;
      wr_sync_q <= '0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      block_q   <= block_q & (raw_rd | raw_wr);
      rd_sync_q <= {rd_sync_q[0], g_rd};
      wr_sync_q <= {wr_sync_q[0], g_wr};
      rd_prev_q <= rd_sync_q[1];
      wr_prev_q <= wr_sync_q[1];
      if (g_rd & g_wr) begin
        abort_q <= 1'b1;
      end else if (bus_idle) begin
        abort_q <= 1'b0;
      end
    end
  end

  // Address/data capture on every cycle a strobe is active; last sample wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (g_rd) begin
        rd_addr_q <= addr;
        rd_data_q <= rd_val;
      end
      if (g_wr) begin
        wr_addr_q <= addr;
        wr_data_q <= d;
      end
    end
  end

  // Register file, cleared on reset, written at write completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else if (reg_we) begin
      regs_q[reg_idx(wr_addr_q)] <= wr_data_q;
    end
  end

  // Occupancy next-state: simultaneous push and pop leaves the count unchanged
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    if (rx_push_ok && !rx_pop_ok) rx_cnt_d = rx_cnt_q + (PW+1)'(1);
    else if (rx_pop_ok && !rx_push_ok) rx_cnt_d = rx_cnt_q - (PW+1)'(1);
    if (tx_push_ok && !tx_pop_ok) tx_cnt_d = tx_cnt_q + (PW+1)'(1);
    else if (tx_pop_ok && !tx_push_ok) tx_cnt_d = tx_cnt_q - (PW+1)'(1);
  end

  // FIFO pointers and counts; pointers wrap naturally at FDEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (rx_push_ok) rx_wptr_q <= rx_wptr_q + PW'(1);
      if (rx_pop_ok)  rx_rptr_q <= rx_rptr_q + PW'(1);
      if (tx_push_ok) tx_wptr_q <= tx_wptr_q + PW'(1);
      if (tx_pop_ok)  tx_rptr_q <= tx_rptr_q + PW'(1);
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // FIFO storage; contents are masked by the counts so no reset is needed
  always_ff @(posedge clk) begin
    if (rx_push_ok) rx_mem[rx_wptr_q] <= rx_wdata;
    if (tx_push_ok) tx_mem[tx_wptr_q] <= wr_data_q;
  end

  // Access log pulse and completed-access counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid_q <= 1'b0;
      log_addr_q  <= '0;
      log_rnw_q   <= 1'b0;
      log_data_q  <= '0;
      acc_cnt_q   <= '0;
    end else begin
      log_valid_q <= rd_commit | wr_commit;
      if (rd_commit) begin
        log_addr_q <= rd_addr_q;
        log_rnw_q  <= 1'b1;
        log_data_q <= rd_data_q;
      end else if (wr_commit) begin
        log_addr_q <= wr_addr_q;
        log_rnw_q  <= 1'b0;
        log_data_q <= wr_data_q;
      end
      if (rd_commit | wr_commit) acc_cnt_q <= acc_cnt_q + 16'd1;
    end
  end

  // Level interrupt, registered from the current mask and RX occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_n_q <= 1'b1;
    end else begin
      int_n_q <= ~(regs_q[IMR_IDX][0] & (rx_cnt_q >= LVL_C));
    end
  end

  assign log_valid = log_valid_q;
  assign log_addr  = log_addr_q;
  assign log_rnw   = log_rnw_q;
  assign log_data  = log_data_q;
  assign acc_cnt   = acc_cnt_q;
  assign int_n     = int_n_q;

`ifdef W5300_BUS_MODEL_ERRCHK_EN
  logic [1:0] rd_len_q, wr_len_q;
  logic       err_q;
  logic       ev_ovl, ev_rx_empty, ev_tx_full, ev_push_full, ev_pop_empty, ev_short;

  assign ev_ovl       = g_rd & g_wr;
  assign ev_rx_empty  = rd_commit & (rd_addr_q == FADDR) & rx_empty;
  assign ev_tx_full   = wr_commit & (wr_addr_q == FADDR) & ~tx_push_ok;
  assign ev_push_full = rx_push & ~rx_push_ok;
  assign ev_pop_empty = tx_pop & tx_empty;
  assign ev_short     = ((rd_len_q == 2'd1) & ~g_rd) | ((wr_len_q == 2'd1) & ~g_wr);

  // Sticky protocol-event flag with strobe-width measurement and diagnostics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_len_q <= '0;
      wr_len_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_len_q <= g_rd ? ((rd_len_q == 2'd2) ? 2'd2 : rd_len_q + 2'd1) : 2'd0;
      wr_len_q <= g_wr ? ((wr_len_q == 2'd2) ? 2'd2 : wr_len_q + 2'd1) : 2'd0;
      err_q    <= err_q | ev_ovl | ev_rx_empty | ev_tx_full | ev_push_full | ev_pop_empty | ev_short;
      if (ev_ovl)       $display("%0t w5300_bus_model: read/write strobe overlap", $time);
      if (ev_rx_empty)  $display("%0t w5300_bus_model: FIFO read with RX empty", $time);
      if (ev_tx_full)   $display("%0t w5300_bus_model: FIFO write with TX full", $time);
      if (ev_push_full) $display("%0t w5300_bus_model: bench push with RX full", $time);
      if (ev_pop_empty) $display("%0t w5300_bus_model: bench pop with TX empty", $time);
      if (ev_short)     $display("%0t w5300_bus_model: strobe shorter than 2 clk", $time);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_w5300_bus_model.sv
// Testbench for w5300_bus_model: scoreboarded access log plus a queue-based model
// of the register file, RX/TX FIFOs, interrupt level and access counter.
module tb_w5300_bus_model;

  localparam int         REGS   = 64;
  localparam int         FDEPTH = 16;
  localparam logic [9:0] FIFO_A = 10'h02E;
  localparam logic [9:0] IMR_A  = 10'h002;
`ifdef W5300_BUS_MODEL_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] addr;
  logic       cs_n, rd_n, wr_n;
  wire  [7:0] d;
  logic [7:0] tb_d;
  logic       tb_den;
  logic       int_n;
  logic       rx_push;
  logic [7:0] rx_wdata;
  logic       rx_full;
  logic [4:0] rx_count;
  logic       tx_pop;
  logic [7:0] tx_rdata;
  logic       tx_empty;
  logic       log_valid;
  logic [9:0] log_addr;
  logic       log_rnw;
  logic [7:0] log_data;
  logic [15:0] acc_cnt;
  logic       err;

  assign d = tb_den ? tb_d : 8'hzz;

  always #5 clk = ~clk;

  w5300_bus_model dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .d(d),
    .int_n(int_n), .rx_push(rx_push), .rx_wdata(rx_wdata), .rx_full(rx_full), .rx_count(rx_count),
    .tx_pop(tx_pop), .tx_rdata(tx_rdata), .tx_empty(tx_empty), .log_valid(log_valid),
    .log_addr(log_addr), .log_rnw(log_rnw), .log_data(log_data), .acc_cnt(acc_cnt), .err(err)
  );

  typedef struct packed {
    logic [9:0] a;
    logic       rnw;
    logic [7:0] v;
  } log_t;

  // Reference model
  logic [7:0] m_reg [REGS];
  logic [7:0] m_rx [$];
  logic [7:0] m_tx [$];
  int         m_acc;
  bit         m_err;
  log_t       exp_q [$];
  log_t       mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int s_lat, s_zero, s_hi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every log pulse is matched against the oldest expected access
  always @(negedge clk) begin
    if (log_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("log_unexpected", 32'(log_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("log_addr", 32'(log_addr), 32'(mon_e.a));
        chk("log_rnw",  32'(log_rnw),  32'(mon_e.rnw));
        chk("log_data", 32'(log_data), 32'(mon_e.v));
      end
    end
  end

  // Observe the cycles after a strobe release: log latency, RX drain and int release
  task automatic settle();
    s_lat = -1; s_zero = -1; s_hi = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (log_valid && s_lat < 0) s_lat = i;
      if (rx_count == 0 && s_zero < 0) s_zero = i;
      if (int_n && s_hi < 0) s_hi = i;
    end
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [7:0] v);
    log_t le;
    @(posedge clk); #1;
    addr = a; tb_d = v; tb_den = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    le.a = a; le.rnw = 1'b0; le.v = v;
    exp_q.push_back(le);
    m_acc++;
    if (a == FIFO_A) begin
      if (m_tx.size() < FDEPTH) m_tx.push_back(v);
      else m_err = 1'b1;
    end else begin
      m_reg[int'(a) % REGS] = v;
    end
    repeat (3) @(posedge clk);
    #1; wr_n = 1'b1; cs_n = 1'b1; tb_den = 1'b0;
    settle();
    chk("wr_log_latency", 32'(s_lat), 32'd3);
  endtask

  task automatic bus_read(input logic [9:0] a);
    log_t       le;
    logic [7:0] e;
    @(posedge clk); #1;
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    if (a == FIFO_A) begin
      if (m_rx.size() > 0) e = m_rx.pop_front();
      else begin e = 8'h00; m_err = 1'b1; end
    end else begin
      e = m_reg[int'(a) % REGS];
    end
    le.a = a; le.rnw = 1'b1; le.v = e;
    exp_q.push_back(le);
    m_acc++;
    @(negedge clk);
    chk("rd_bus_data", 32'(d), 32'(e));
    repeat (2) @(posedge clk);
    #1; rd_n = 1'b1; cs_n = 1'b1;
    settle();
    chk("rd_log_latency", 32'(s_lat), 32'd3);
  endtask

  task automatic bench_push(input logic [7:0] v);
    @(posedge clk); #1;
    rx_push = 1'b1; rx_wdata = v;
    if (m_rx.size() < FDEPTH) m_rx.push_back(v);
    else m_err = 1'b1;
    @(posedge clk); #1;
    rx_push = 1'b0;
  endtask

  task automatic bench_pop();
    @(posedge clk); #1;
    tx_pop = 1'b1;
    if (m_tx.size() > 0) void'(m_tx.pop_front());
    else m_err = 1'b1;
    @(posedge clk); #1;
    tx_pop = 1'b0;
  endtask

  task automatic check_state(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rx_count"}, 32'(rx_count), 32'(m_rx.size()));
    chk({tag, ".rx_full"},  32'(rx_full),  32'(m_rx.size() == FDEPTH));
    chk({tag, ".tx_empty"}, 32'(tx_empty), 32'(m_tx.size() == 0));
    if (m_tx.size() > 0) chk({tag, ".tx_rdata"}, 32'(tx_rdata), 32'(m_tx[0]));
    chk({tag, ".int_n"},    32'(int_n),    32'(!(m_reg[int'(IMR_A)][0] && m_rx.size() >= 1)));
    chk({tag, ".acc_cnt"},  32'(acc_cnt),  m_acc & 32'hFFFF);
    chk({tag, ".err"},      32'(err),      32'(ERRCHK && m_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < REGS; i++) m_reg[i] = 8'h00;
    m_rx.delete();
    m_tx.delete();
    exp_q.delete();
    m_acc = 0;
    m_err = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [9:0] ra;
    addr = '0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    tb_d = '0; tb_den = 1'b0; rx_push = 1'b0; rx_wdata = '0; tx_pop = 1'b0;
    model_reset();

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.int_n",     32'(int_n),     32'd1);
    chk("rst.acc_cnt",   32'(acc_cnt),   32'd0);
    chk("rst.log_valid", 32'(log_valid), 32'd0);
    chk("rst.rx_count",  32'(rx_count),  32'd0);
    chk("rst.tx_empty",  32'(tx_empty),  32'd1);
    chk("rst.err",       32'(err),       32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Register write then read back
    bus_write(10'h010, 8'hA5);
    bus_read(10'h010);
    check_state("regrw");

    // RX path and interrupt release one clock after RX drains
    bus_write(IMR_A, 8'h01);
    bench_push(8'h11);
    bench_push(8'h22);
    check_state("rx_int");
    bus_read(FIFO_A);
    bus_read(FIFO_A);
    chk("int_release_delay", 32'(s_hi - s_zero), 32'd1);
    check_state("rx_drain");

    // TX path: five writes then five pops in order
    for (int i = 1; i <= 5; i++) bus_write(FIFO_A, 8'(i));
    check_state("tx_fill");
    for (int i = 1; i <= 5; i++) begin
      bench_pop();
      check_state("tx_pop");
    end

    // RX boundary: 17th push dropped, then drain plus one empty read
    for (int i = 0; i < 17; i++) bench_push(8'h40 + 8'(i));
    check_state("rx_full");
    for (int i = 0; i < 17; i++) bus_read(FIFO_A);
    check_state("rx_empty_read");

    // Reset while a write strobe is active: nothing commits or logs
    @(posedge clk); #1;
    addr = 10'h020; tb_d = 8'h5A; tb_den = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    wr_n = 1'b1; cs_n = 1'b1; tb_den = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    check_state("mid_reset");
    bus_read(10'h020);
    check_state("mid_reset_rd");

    // Read/write overlap: no commit, no log
    bus_write(10'h030, 8'h3C);
    @(posedge clk); #1;
    addr = 10'h030; cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    m_err = 1'b1;
    repeat (8) @(posedge clk);
    check_state("overlap");
    bus_read(10'h030);

    // Randomised mix against the model
    for (int n = 0; n < 200; n++) begin
      ra = 10'($urandom_range(0, 1023));
      if (ra == FIFO_A) ra = ra + 10'd1;
      case ($urandom_range(0, 6))
        0: bus_write(ra, 8'($urandom_range(0, 255)));
        1: bus_read(ra);
        2: bench_push(8'($urandom_range(0, 255)));
        3: bus_read(FIFO_A);
        4: bus_write(FIFO_A, 8'($urandom_range(0, 255)));
        5: bench_pop();
        default: bus_write(IMR_A, 8'($urandom_range(0, 255)));
      endcase
      check_state("rand");
    end

    repeat (10) @(posedge clk);
    chk("log_missing", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/w5300_bus_model.md
Name: w5300_bus_model

Overview:
- Clocked, parametrised W5300 host-bus slave model for CPLD testbenches.
- Replaces edge-triggered, untimed checking with a synchronised, cycle-accurate slave that contains:
  - a register file;
  - an RX/TX FIFO data window, as on the W5300 socket FIFO registers;
  - a level-based interrupt;
  - an access log.
- Sits on the chip-side bus of the CPLD under test. The bench drives the FIFO side and reads the log.

Parameters:
- AW, 10, bus address width.
- DW, 8, bus data width (8 or 16).
- REGS, 64, register file depth; register index = addr modulo REGS.
- FIFO_ADDR, 10'h02E, address of the FIFO data window.
- IMR_ADDR, 10'h002, address of the interrupt mask register; bit0 enables the RX interrupt.
- FDEPTH, 16, depth of each FIFO (power of two).
- INT_LEVEL, 1, RX occupancy at or above which the interrupt is requested.

Ports:
- clk  in  1  model clock; must be at least 4x faster than the bus strobes.
- rst_n  in  1  asynchronous active-low reset.
- addr  in  AW  bus address.
- cs_n  in  1  chip select, active low.
- rd_n  in  1  read strobe, active low.
- wr_n  in  1  write strobe, active low.
- d  inout  DW  bus data.
- int_n  out  1  interrupt, active low, registered.
- rx_push  in  1  bench pushes rx_wdata into the RX FIFO.
- rx_wdata  in  DW  RX push data.
- rx_full  out  1  RX FIFO full.
- rx_count  out  log2(FDEPTH)+1  RX occupancy.
- tx_pop  in  1  bench pops the TX FIFO.
- tx_rdata  out  DW  TX FIFO head (show-ahead).
- tx_empty  out  1  TX FIFO empty.
- log_valid  out  1  one-cycle pulse per completed bus access.
- log_addr  out  AW  address of that access.
- log_rnw  out  1  1 = read, 0 = write.
- log_data  out  DW  data written, or data returned on the read.
- acc_cnt  out  16  completed-access counter; wraps at 16'hFFFF to 0.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Strobe decode and synchronisation:
  - raw_rd = ~(cs_n|rd_n); raw_wr = ~(cs_n|wr_n).
  - Both pass through 2-flop synchronisers to give s_rd and s_wr.
  - Start of an access = s_x rising edge; end of an access = s_x falling edge.
- Read data path:
  - d is driven combinationally while raw_rd = 1, and is Z otherwise.
  - Value on d: rx head if addr == FIFO_ADDR; else regfile[addr % REGS].
  - For an empty-FIFO read, d returns {DW{1'b0}}.
- Read address/data capture: every clk with raw_rd = 1, the current addr and the value driven on d are registered.
- Read completion, on the s_rd falling edge:
  - If the access was to FIFO_ADDR and RX is not empty, RX pops once.
  - log_valid pulses for one cycle, log_rnw = 1, log_data = the registered data.
  - acc_cnt increments.
  - Read-to-log latency: 3 clk after raw_rd deassert.
- Write capture: every clk with raw_wr = 1, addr and d are registered. The last sampled value before deassert is the committed one.
- Write completion, on the s_wr falling edge:
  - FIFO_ADDR: push into TX, or drop if TX is full.
  - Otherwise: regfile[addr % REGS] is written.
  - log_valid pulses with log_rnw = 0; acc_cnt increments.
- FIFO occupancy rules:
  - Bench rx_push with RX full is ignored.
  - Bench tx_pop with TX empty is ignored.
  - Simultaneous push and pop on the same FIFO: count is unchanged and both the data and the pointer operations take effect.
  - Pointers wrap modulo FDEPTH.
- Interrupt:
  - int_n is registered: int_n <= ~(regfile[IMR_ADDR][0] & (rx_count >= INT_LEVEL)).
  - int_n deasserts 1 clk after the condition clears.
  - A write to IMR takes effect 1 clk after commit.
- Simultaneous raw_rd and raw_wr: neither access commits, and err is set when the error-check feature is enabled.
- Reset state and reset mid-access:
  - Reset clears: regfile, pointers, counts, log outputs, acc_cnt and err, all to 0; int_n = 1; synchronisers cleared.
  - A bus access in flight during reset is discarded: no pop, commit or log.

Optional Feature:
- Macro: W5300_BUS_MODEL_ERRCHK_EN.
- Defined:
  - err is set (sticky until reset) on: raw_rd & raw_wr overlap; a bus read of FIFO_ADDR with RX empty; a bus write of FIFO_ADDR with TX full; bench push when full; bench pop when empty; a strobe shorter than 2 clk (synchroniser miss).
  - Each event also issues a $display with the time and the cause.
- Undefined: err is tied to 0, and no checks or messages are generated.

Test Plan:
- Reg write/read: write 8'hA5 to addr 10'h010, then read 10'h010 -> d = 8'hA5 during the strobe; log shows (10'h010, rnw 0, A5) then (10'h010, rnw 1, A5); acc_cnt = 2.
- RX path and interrupt:
  - Write IMR = 8'h01, then bench pushes 8'h11 and 8'h22 -> int_n goes low.
  - Two reads of FIFO_ADDR return 8'h11 then 8'h22; rx_count reaches 0; int_n high 1 clk later.
- TX path: five bus writes 1..5 to FIFO_ADDR -> tx_empty = 0 and tx_rdata = 1; after five tx_pop pulses tx_rdata has shown 1..5 in order and tx_empty = 1.
- FIFO boundaries: push 17 bench words with FDEPTH = 16 -> rx_full = 1, rx_count = 16, 17th word dropped; err = 1 with the macro defined, 0 without.
- Reset mid-write: assert rst_n low while wr_n is low on addr 10'h020 with data 8'h5A -> after release, regfile[10'h020] = 0, acc_cnt = 0, int_n = 1, no log pulse.
- Overlap: hold rd_n and wr_n low together with cs_n low -> no commit and no log pulse; err = 1 with the macro defined.
